// File: rtl/led_toggle_counter_pkg.sv
// Shared types and constants for the LED blink counter.
`timescale 1ns/1ps
package led_toggle_counter_pkg;

    localparam int unsigned CNT_W = 25;

    typedef logic [CNT_W-1:0] cnt_t;

    // 50 MHz / 25_000_000 per half period gives a 1 Hz blink
    localparam cnt_t CNT_MAX_DEFAULT = 25'd24_999_999;

endpackage

// File: rtl/led_toggle_counter_if.sv
// Output bundle of the LED blink counter; cnt_flag exists only when
// LED_TOGGLE_COUNTER_FLAG_EN is defined.
`timescale 1ns/1ps
interface led_toggle_counter_if;

    logic led_out;

`ifdef LED_TOGGLE_COUNTER_FLAG_EN
    logic cnt_flag;

    modport master (output led_out, output cnt_flag);
    modport slave  (input  led_out, input  cnt_flag);
`else
    modport master (output led_out);
    modport slave  (input  led_out);
`endif

endinterface

// File: rtl/led_toggle_counter_mod_counter.sv
// Free-running 0..cnt_max counter with a registered flag that is high
// exactly while cnt == cnt_max.
`timescale 1ns/1ps
module mod_counter
    import led_toggle_counter_pkg::*;
#(
    parameter cnt_t cnt_max = CNT_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output cnt_t cnt,
    output logic flag
);

    // A zero terminal count would leave the flag stuck low
    if (cnt_max == cnt_t'(0)) begin : g_bad_cnt_max
        $error("mod_counter: cnt_max must be in 1..2^25-1");
    end

    // Flag is loaded one count early so it lines up with the terminal count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            cnt  <= (cnt == cnt_max) ? '0 : cnt + cnt_t'(1);
            flag <= (cnt == cnt_max - cnt_t'(1));
        end
    end

endmodule

// File: rtl/led_toggle_counter.sv
// LED square-wave generator: toggles led_out once per cnt_max+1 clocks.
// Define LED_TOGGLE_COUNTER_FLAG_EN to expose the terminal-count pulse as cnt_flag.
`timescale 1ns/1ps
module led_toggle_counter
    import led_toggle_counter_pkg::*;
#(
    parameter cnt_t cnt_max = CNT_MAX_DEFAULT
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    led_toggle_counter_if.master  led_if
);

    cnt_t cnt;
    logic flag;
    logic led_q;
    logic unused_cnt;

    mod_counter #(
        .cnt_max (cnt_max)
    ) u_mod_counter (
        .clk   (sys_clk),
        .rst_n (sys_rst),
        .cnt   (cnt),
        .flag  (flag)
    );

    // The count itself is only observed for debug; flag carries the timing
    assign unused_cnt = ^cnt;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            led_q <= 1'b0;
        end else if (flag) begin
            led_q <= ~led_q;
        end
    end

    assign led_if.led_out = led_q;

`ifdef LED_TOGGLE_COUNTER_FLAG_EN
    assign led_if.cnt_flag = flag;
`endif

endmodule

// File: tb/tb_led_toggle_counter.sv
// Scoreboard bench: a cnt_max=24 instance and a cnt_max=1 instance share clock and reset.
`timescale 1ns/1ps
module tb_led_toggle_counter;
    import led_toggle_counter_pkg::*;

    localparam int unsigned P0 = 25;   // period of the cnt_max=24 instance
    localparam int unsigned P1 = 2;    // period of the cnt_max=1 instance

    typedef struct packed {
        cnt_t cnt;
        logic flag;
        logic led;
        cnt_t cnt1;
        logic flag1;
        logic led1;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    exp_t q[$];
    time  led_edges[$];
    bit   rec_en = 1'b0;
    int   flag_pulses = 0;

    led_toggle_counter_if if0 ();
    led_toggle_counter_if if1 ();

    led_toggle_counter #(.cnt_max(25'd24)) dut (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .led_if  (if0)
    );

    led_toggle_counter #(.cnt_max(25'd1)) dut1 (
        .sys_clk (clk),
        .sys_rst (sys_rst),
        .led_if  (if1)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Closed-form expectation after k edges since reset release
    function automatic exp_t exp_at(input int unsigned k);
        exp_t e;
        e.cnt   = cnt_t'(k % P0);
        e.flag  = (k % P0) == (P0 - 1);
        e.led   = ((k / P0) % 2) == 1;
        e.cnt1  = cnt_t'(k % P1);
        e.flag1 = (k % P1) == (P1 - 1);
        e.led1  = ((k / P1) % 2) == 1;
        return e;
    endfunction

    // Monitor: one expectation per clock, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("cnt",      32'(dut.cnt),      32'(e.cnt));
            check("flag",     32'(dut.flag),     32'(e.flag));
            check("led_out",  32'(if0.led_out),  32'(e.led));
            check("cnt1",     32'(dut1.cnt),     32'(e.cnt1));
            check("led_out1", 32'(if1.led_out),  32'(e.led1));
`ifdef LED_TOGGLE_COUNTER_FLAG_EN
            check("cnt_flag",      32'(if0.cnt_flag), 32'(e.flag));
            check("cnt_flag_int",  32'(if0.cnt_flag), 32'(dut.flag));
            check("cnt_flag1",     32'(if1.cnt_flag), 32'(e.flag1));
`else
            check("flag1",    32'(dut1.flag),    32'(e.flag1));
`endif
            if (rec_en && dut.flag) flag_pulses++;
        end
    end

    always @(if0.led_out) begin
        if (rec_en) led_edges.push_back($time);
    end

    initial begin
        time edge_exp[4] = '{510, 1010, 1510, 2010};

        // Reset held across the edge at 10 ns
        @(posedge clk);
        q.push_back(exp_at(0));
        #10 sys_rst = 1'b1;

        // Run-up, first toggle and three steady-state periods (edges 1..100)
        rec_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            q.push_back(exp_at(k));
        end
        @(negedge clk);
        rec_en = 1'b0;
        check("led_edge_count", 32'(led_edges.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < led_edges.size())
                check("led_edge_time", 32'(led_edges[i]), 32'(edge_exp[i]));
        end
        check("flag_pulses", 32'(flag_pulses), 32'd4);

        // Advance to cnt == 13 with led_out == 1 (edge 138)
        for (int k = 101; k <= 138; k++) begin
            @(posedge clk);
            q.push_back(exp_at(k));
        end

        // Asynchronous reset after the mid-cycle sample, checked before the next edge
        #15 sys_rst = 1'b0;
        #1;
        check("rst_async_cnt",  32'(dut.cnt),     32'd0);
        check("rst_async_flag", 32'(dut.flag),    32'd0);
        check("rst_async_led",  32'(if0.led_out), 32'd0);
        check("rst_async_led1", 32'(if1.led_out), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            q.push_back(exp_at(0));
        end
        #5 sys_rst = 1'b1;

        // Fresh count after release: first toggle on edge 25
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            q.push_back(exp_at(k));
        end

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_toggle_counter.md
# led_toggle_counter

Free-running modulo counter that drives a square-wave LED output, toggling `led_out` once per full count period. It sits at the board top level between the system clock and an indicator LED. With the default parameter at a 50 MHz clock, it gives a 1 Hz blink: 0.5 s high and 0.5 s low. A testbench overrides `cnt_max` to shorten the period.

## Interface
- `cnt_max`, default 25'd24_999_999: terminal count. The counter runs 0..`cnt_max`, so the period is `cnt_max`+1 clocks. Width is 25 bits. Legal range is 1..2^25−1.
- `sys_clk`  input  1  system clock; all state updates on its rising edge. One clock domain.
- `sys_rst`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `led_out`  output 1  LED drive; registered square wave.
- `cnt_flag` output 1  present only when `LED_TOGGLE_COUNTER_FLAG_EN` is defined: one-cycle terminal-count pulse.

## Operation
- `cnt` (25-bit register):
  - Reset value is 0.
  - Each rising edge: if `cnt == cnt_max`, `cnt` becomes 0; otherwise it increments by 1.
  - The increment is unsigned 25-bit and never overflows within the legal range.
- `flag` (internal register):
  - Reset value is 0.
  - Each edge it loads (`cnt == cnt_max − 1`).
  - It is therefore high for exactly the one cycle in which `cnt == cnt_max`.
- `led_out` register:
  - Reset value is 0.
  - On an edge where `flag == 1`, it inverts; otherwise it holds.
- No enable, no load and no other inputs; the counter always runs out of reset.
- Reset asserted mid-count:
  - `cnt`, `flag` and `led_out` clear immediately, without waiting for a clock edge.
  - Counting restarts from 0 on the first rising edge after `sys_rst` returns high.
  - No partial period is carried over.
- `cnt_max == 1`: `flag` is high every other cycle, so `led_out` toggles every 2 clocks.
- `cnt_max == 0` is illegal. Guard it with an elaboration-time check that reports an error.

## Timing
- Edge numbering: edge 1 is the first rising edge with `sys_rst` high.
  - After edge k (k ≤ `cnt_max`), `cnt == k`.
  - `flag` rises after edge `cnt_max`.
  - `led_out` first toggles on edge `cnt_max`+1.
- Steady state: `led_out` toggles every `cnt_max`+1 clocks, giving a 50 % duty cycle and a full period of 2×(`cnt_max`+1) clocks.
- `led_out` is register-driven, with no combinational path from any input.
- Reset to output: asynchronous, zero clock latency.

## Configuration
- Macro `LED_TOGGLE_COUNTER_FLAG_EN`.
- Defined: port `cnt_flag` exists and is driven directly by the internal `flag` register. It is a one-cycle pulse coincident with `cnt == cnt_max`, reset to 0.
- Undefined: no `cnt_flag` port; `flag` stays internal. `led_out` behaviour is identical in both builds.

## Structure
- Shared package `led_toggle_counter_pkg` holds:
  - `CNT_W` = 25, the counter width;
  - `CNT_MAX_DEFAULT` = 25'd24_999_999;
  - a typedef `cnt_t` for the 25-bit count.
- One natural sub-module, `mod_counter`:
  - parameter: terminal count;
  - inputs: clock, reset;
  - outputs: count value and the registered early-terminal flag.
- The top level instantiates `mod_counter` and adds the `led_out` toggle register.

## Test plan
Use `cnt_max = 24`, a 20 ns clock, and reset released at 20 ns, so edge 1 is at 30 ns.
- Reset held low: `led_out` = 0, `cnt` = 0 and `flag` = 0 throughout, regardless of clock activity.
- Release reset: `cnt` reads 24 after edge 24 (490 ns). `flag` is high only in the cycle between edges 24 and 25. `led_out` goes 0→1 at edge 25 (510 ns).
- Steady state: `led_out` edges at 510, 1010, 1510 and 2010 ns, each 500 ns apart. High and low times are both 25 clocks.
- Wrap: `cnt` goes 24→0 on edge 25 and never reads 25 or more. `flag` pulses exactly once per 25 cycles.
- Mid-count reset: drive `sys_rst` low between clock edges when `cnt` = 13 and `led_out` = 1. `cnt` and `led_out` clear to 0 before the next edge. After release, the first toggle occurs on edge 25 counted from the release.
- With `LED_TOGGLE_COUNTER_FLAG_EN` defined: `cnt_flag` matches the internal `flag` every cycle, and `cnt_max = 1` gives a `cnt_flag` pattern of 0,1,0,1 and `led_out` toggling every 2 clocks.
